// File: rtl/amp_trig2.sv
// Amplifier trigger generator: on an enabled rising edge of trigger_in, wait a
// captured delay, then drive amp_trig high for PULSE_LEN cycles.
module amp_trig2 #(
    parameter int unsigned PULSE_LEN = 32,
    parameter int unsigned DLY_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger_in,
    input  logic             trig_out_en_b,
    input  logic [DLY_W-1:0] trig_out_delay_b,
    output logic             amp_trig
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

    logic             armed_q;
    logic             trig_q;
    logic [1:0]       state_q,   state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [7:0]       pls_cnt_q, pls_cnt_d;
    logic             amp_q,     amp_d;
    logic             trig_edge;

    // Reset release is taken up by armed_q on the first edge; the datapath
    // starts on the second, so trig_q still reads 0 there and a level already
    // high at release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign trig_edge = trigger_in & ~trig_q;

    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        pls_cnt_d = pls_cnt_q;
        amp_d     = amp_q;

        if (!trig_out_en_b) begin
            state_d   = ST_IDLE;
            dly_cnt_d = '0;
            pls_cnt_d = '0;
            amp_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    amp_d = 1'b0;
                    if (trig_edge) begin
                        state_d   = ST_DELAY;
                        dly_cnt_d = trig_out_delay_b;
                    end
                end
                ST_DELAY: begin
                    amp_d = 1'b0;
                    if (dly_cnt_q == '0) begin
                        state_d   = ST_PULSE;
                        amp_d     = 1'b1;
                        pls_cnt_d = PULSE_LAST;
                    end else begin
                        dly_cnt_d = dly_cnt_q - DLY_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (pls_cnt_q == '0) begin
                        state_d = ST_IDLE;
                        amp_d   = 1'b0;
                    end else begin
                        pls_cnt_d = pls_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    dly_cnt_d = '0;
                    pls_cnt_d = '0;
                    amp_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q    <= 1'b0;
            state_q   <= ST_IDLE;
            dly_cnt_q <= '0;
            pls_cnt_q <= '0;
            amp_q     <= 1'b0;
        end else if (armed_q) begin
            trig_q    <= trigger_in;
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            pls_cnt_q <= pls_cnt_d;
            amp_q     <= amp_d;
        end
    end

    assign amp_trig = amp_q;

endmodule

// File: tb/tb_amp_trig2.sv
// Bench for amp_trig2: directed scenarios plus randomized traffic, checked
// every cycle against an event-time model (rise/fall cycle numbers).
module tb_amp_trig2;

    localparam int unsigned PL = 32;
    localparam int unsigned DW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger_in = 1'b0;
    logic          trig_out_en_b = 1'b0;
    logic [DW-1:0] trig_out_delay_b = '0;
    logic          amp_trig;

    amp_trig2 #(.PULSE_LEN(PL), .DLY_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trigger_in       (trigger_in),
        .trig_out_en_b    (trig_out_en_b),
        .trig_out_delay_b (trig_out_delay_b),
        .amp_trig         (amp_trig)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a sequence is fixed by its rise and end cycle numbers.
    longint cyc_no   = 0;
    bit     seq      = 1'b0;
    longint rise_c   = 0;
    longint end_c    = 0;
    bit     prev_t   = 1'b0;
    int     since_rel = 0;
    bit     exp_amp  = 1'b0;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    endtask

    task automatic model_edge(input bit t, input bit e, input int d);
        bit idle_before;
        cyc_no++;
        if (since_rel < 1) begin
            since_rel++;
            prev_t  = 1'b0;
            seq     = 1'b0;
            exp_amp = 1'b0;
            return;
        end
        idle_before = !seq || (cyc_no > end_c);
        if (!e) begin
            seq = 1'b0;
        end else if (idle_before && t && !prev_t) begin
            seq    = 1'b1;
            rise_c = cyc_no + 1 + d;
            end_c  = rise_c + PL;
        end
        prev_t  = t;
        exp_amp = seq && (cyc_no >= rise_c) && (cyc_no < end_c);
    endtask

    // Called just after a check (clock high); drives, clocks, models, checks.
    task automatic cyc(input string tag, input bit t, input bit e, input int d);
        trigger_in       = t;
        trig_out_en_b    = e;
        trig_out_delay_b = DW'(d);
        @(posedge clk);
        model_edge(t, e, d);
        #1;
        check(tag, amp_trig, exp_amp);
    endtask

    task automatic do_reset(input bit t, input int hold);
        #2;
        rst_n      = 1'b0;
        trigger_in = t;
        #1;
        check("rst_async", amp_trig, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", amp_trig, 1'b0);
        end
        rst_n     = 1'b1;
        seq       = 1'b0;
        prev_t    = 1'b0;
        since_rel = 0;
        exp_amp   = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input bit t, input bit e, input int d);
        for (int i = 0; i < n; i++) cyc(tag, t, e, d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", amp_trig, 1'b0);
        rst_n = 1'b1;
        run("idle", 5, 1'b0, 1'b1, 1);

        // Long held trigger, D=1: one pulse only.
        run("held_d1", 900, 1'b1, 1'b1, 1);
        run("held_d1_low", 5, 1'b0, 1'b1, 1);

        // D=0 and D=127 extremes.
        run("d0", 45, 1'b1, 1'b1, 0);
        run("d0_low", 3, 1'b0, 1'b1, 0);
        run("d127", 170, 1'b1, 1'b1, 127);
        run("d127_low", 3, 1'b0, 1'b1, 127);

        // Disabled triggers ignored; disable mid-pulse aborts.
        for (int k = 0; k < 4; k++) begin
            run("dis", 3, 1'b1, 1'b0, 2);
            run("dis", 3, 1'b0, 1'b0, 2);
        end
        run("abort", 15, 1'b1, 1'b1, 2);
        run("abort_en0", 2, 1'b1, 1'b0, 2);
        run("abort_after", 40, 1'b0, 1'b1, 2);

        // D=10 with extra edges at n+5 and n+20, then a fresh edge later.
        for (int i = 0; i < 60; i++)
            cyc("retrig", (i < 2) || (i >= 5 && i < 8) || (i >= 20 && i < 25), 1'b1, 10);
        run("retrig_new", 50, 1'b1, 1'b1, 10);
        run("retrig_low", 3, 1'b0, 1'b1, 10);

        // Delay input changed after capture.
        for (int i = 0; i < 50; i++) cyc("dchg", 1'b1, 1'b1, (i < 3) ? 10 : 50);
        run("dchg_low", 3, 1'b0, 1'b1, 50);

        // Reset mid-pulse, trigger low afterwards: no pulse.
        run("rst_pulse", 10, 1'b1, 1'b1, 0);
        do_reset(1'b0, 2);
        run("rst_after", 50, 1'b0, 1'b1, 0);

        // Trigger already high at reset release counts as an edge.
        do_reset(1'b1, 2);
        run("rst_level", 45, 1'b1, 1'b1, 3);
        run("rst_level_low", 3, 1'b0, 1'b1, 3);

        // Randomized traffic.
        begin
            bit t = 1'b0;
            bit e = 1'b1;
            int d = 5;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 29) == 0) t = ~t;
                if ($urandom_range(0, 199) == 0) e = 1'b0;
                else if (!e && $urandom_range(0, 3) == 0) e = 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0: d = 0;
                        1: d = 127;
                        default: d = $urandom_range(0, 40);
                    endcase
                end
                if ($urandom_range(0, 799) == 0) do_reset(t, $urandom_range(1, 3));
                cyc("rand", t, e, d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
